unified_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch (IF) requester and the data (MEM-stage) requester of the pipelined core.
- Serializes the two requests, captures returned read data per requester, and produces `pipe_load`.
- `pipe_load` drives the Load input of every pipeline/PC register: the pipeline advances only when all pending accesses for the current cycle are complete.
- Includes a memory-response timeout that raises a sticky error.

---
 rtl/unified_mem_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-port unified memory between the instruction
//            fetch requester and the data (MEM-stage) requester. Data accesses
//            win ties. The returned read data is captured per requester. The
//            pipe_load output advances the pipeline only once every pending
//            access for the current cycle has completed. A response timeout
//            aborts a stalled access and raises a sticky error.
// Ports    : clk, rst (sync, active-low)
//            if_req/if_addr -> if_rdata/if_ack            fetch requester
//            d_req/d_we/d_be/d_addr/d_wdata -> d_rdata/d_ack  data requester
//            mem_en/mem_we/mem_be/mem_addr/mem_wdata,
//            mem_rdata/mem_ready                          memory port
//            pipe_load                                    pipeline Load enable
//            err                                          sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                pipe_load,
  output logic                err
);

  localparam int                 C_BE_W  = DATA_W / 8;
  localparam int                 C_CNT_W = $clog2(TIMEOUT);
  localparam logic [C_CNT_W-1:0] C_TERM  = C_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_if_done;
  logic                 r_d_done;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_if_ack;
  logic                 r_d_ack;
  logic [DATA_W-1:0]    r_if_rdata;
  logic [DATA_W-1:0]    r_d_rdata;
  logic                 r_err;
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [C_BE_W-1:0]    r_mem_be;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;

  logic                 w_if_pend;
  logic                 w_d_pend;
  logic                 w_if_go;
  logic                 w_d_go;
  logic                 w_term;
  logic                 w_start_fetch;
  logic                 w_start_data;
  logic                 w_done;
  logic                 w_abort;

  // A requester is pending until its access has been acknowledged within the
  // current pipeline cycle; the ack cycle itself already counts as served.
  assign w_if_pend = if_req & ~r_if_done;
  assign w_d_pend  = d_req  & ~r_d_done;
  assign w_if_go   = w_if_pend & ~r_if_ack;
  assign w_d_go    = w_d_pend  & ~r_d_ack;
  assign w_term    = (r_cnt == C_TERM);

  // Combinational so the pipeline can advance in the same cycle as the last ack.
  assign pipe_load = w_if_go_n() & w_d_go_n() & rst;

  function automatic logic w_if_go_n();
    return ~(w_if_pend & ~r_if_ack);
  endfunction

  function automatic logic w_d_go_n();
    return ~(w_d_pend & ~r_d_ack);
  endfunction

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_start_fetch = 1'b0;
    w_start_data  = 1'b0;
    w_done        = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The data access belongs to the older instruction, so it goes first.
        if (w_d_go) begin
          w_state_nxt  = S_DATA;
          w_start_data = 1'b1;
        end else if (w_if_go) begin
          w_state_nxt   = S_FETCH;
          w_start_fetch = 1'b1;
        end
      end
      S_FETCH, S_DATA: begin
        // A response arriving on the terminal count still wins over the abort.
        if (mem_ready) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else if (w_term) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: memory port, captured read data, acks, done flags, timeout
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_cnt       <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;

      // pipe_load starts a new pipeline cycle, so it outranks a same-cycle ack.
      if (pipe_load) begin
        r_if_done <= 1'b0;
        r_d_done  <= 1'b0;
      end else begin
        if (r_if_ack) r_if_done <= 1'b1;
        if (r_d_ack)  r_d_done  <= 1'b1;
      end

      if (w_start_fetch) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_be    <= '1;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
        r_cnt       <= '0;
      end else if (w_start_data) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_be    <= d_be;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
        r_cnt       <= '0;
      end else if (w_done || w_abort) begin
        r_mem_en    <= 1'b0;
        r_mem_we    <= 1'b0;
        r_mem_be    <= '0;
        r_mem_addr  <= '0;
        r_mem_wdata <= '0;
        r_cnt       <= '0;
        if (r_state == S_FETCH) begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= w_done ? mem_rdata : '0;
        end else begin
          r_d_ack <= 1'b1;
          if (w_abort) begin
            r_d_rdata <= '0;
          end else if (!r_mem_we) begin
            r_d_rdata <= mem_rdata;
          end
        end
        if (w_abort) r_err <= 1'b1;
      end else if (r_mem_en) begin
        r_cnt <= r_cnt + C_CNT_W'(1);
      end
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_ack    = r_if_ack;
  assign d_rdata   = r_d_rdata;
  assign d_ack     = r_d_ack;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_arbiter
// Purpose  : Directed self-checking bench for unified_mem_arbiter. A default
//            instance (TIMEOUT=64) and a short-timeout instance (TIMEOUT=4)
//            share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic [31:0] if_rdata,  if_rdata_t;
  logic        if_ack,    if_ack_t;
  logic [31:0] d_rdata,   d_rdata_t;
  logic        d_ack,     d_ack_t;
  logic        mem_en,    mem_en_t;
  logic        mem_we,    mem_we_t;
  logic [3:0]  mem_be,    mem_be_t;
  logic [31:0] mem_addr,  mem_addr_t;
  logic [31:0] mem_wdata, mem_wdata_t;
  logic        pipe_load, pipe_load_t;
  logic        err,       err_t;

  int n_checks;
  int n_errors;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pipe_load(pipe_load), .err(err)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut_to (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_t), .if_ack(if_ack_t),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_t), .d_ack(d_ack_t),
    .mem_en(mem_en_t), .mem_we(mem_we_t), .mem_be(mem_be_t), .mem_addr(mem_addr_t),
    .mem_wdata(mem_wdata_t), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pipe_load(pipe_load_t), .err(err_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h80; d_req = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL reset_mem_en: got %h want 0", mem_en); end
      n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %h want 0", err); end
      n_checks++; if (pipe_load !== 1'b0) begin n_errors++; $display("FAIL reset_pipe_load: got %h want 0", pipe_load); end
    end
    n_checks++; if (if_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
    rst = 1'b1; #1;
    n_checks++; if (pipe_load !== 1'b0) begin n_errors++; $display("FAIL release_pipe_load: got %h want 0", pipe_load); end
    n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL release_mem_en: got %h want 0", mem_en); end
    tick(); #1;
    n_checks++; if (mem_en !== 1'b1) begin n_errors++; $display("FAIL release_fetch_en: got %h want 1", mem_en); end
    n_checks++; if (mem_addr !== 32'h80) begin n_errors++; $display("FAIL release_fetch_addr: got %h want 00000080", mem_addr); end
    rst = 1'b0;
    tick(); #1;
    n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL abandon_mem_en: got %h want 0", mem_en); end
    n_checks++; if (if_ack !== 1'b0) begin n_errors++; $display("FAIL abandon_if_ack: got %h want 0", if_ack); end
    if_req = 1'b0; rst = 1'b1;
    tick(); #1;
    n_checks++; if (pipe_load !== 1'b1) begin n_errors++; $display("FAIL idle_pipe_load: got %h want 1", pipe_load); end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h00500093; #1;
    n_checks++; if (pipe_load !== 1'b0) begin n_errors++; $display("FAIL fetch_c0_pipe_load: got %h want 0", pipe_load); end
    tick(); #1;
    n_checks++; if (mem_en !== 1'b1) begin n_errors++; $display("FAIL fetch_c1_mem_en: got %h want 1", mem_en); end
    n_checks++; if (mem_addr !== 32'h100) begin n_errors++; $display("FAIL fetch_c1_addr: got %h want 00000100", mem_addr); end
    n_checks++; if (mem_be !== 4'hF) begin n_errors++; $display("FAIL fetch_c1_be: got %h want f", mem_be); end
    n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL fetch_c1_we: got %h want 0", mem_we); end
    tick(); #1;
    n_checks++; if (if_ack !== 1'b1) begin n_errors++; $display("FAIL fetch_c2_ack: got %h want 1", if_ack); end
    n_checks++; if (if_rdata !== 32'h00500093) begin n_errors++; $display("FAIL fetch_c2_rdata: got %h want 00500093", if_rdata); end
    n_checks++; if (pipe_load !== 1'b1) begin n_errors++; $display("FAIL fetch_c2_pipe_load: got %h want 1", pipe_load); end
    n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL fetch_c2_mem_en: got %h want 0", mem_en); end
    if_req = 1'b0;
    tick(); #1;
    n_checks++; if (if_ack !== 1'b0) begin n_errors++; $display("FAIL fetch_c3_ack: got %h want 0", if_ack); end
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h2000; d_wdata = 32'h0;
    mem_rdata = 32'hDEADBEEF; mem_ready = 1'b1; #1;
    n_checks++; if (pipe_load !== 1'b0) begin n_errors++; $display("FAIL cont_c0_pipe_load: got %h want 0", pipe_load); end
    tick(); #1;
    n_checks++; if (mem_addr !== 32'h2000) begin n_errors++; $display("FAIL cont_c1_data_first: got %h want 00002000", mem_addr); end
    n_checks++; if (pipe_load !== 1'b0) begin n_errors++; $display("FAIL cont_c1_pipe_load: got %h want 0", pipe_load); end
    tick(); #1;
    n_checks++; if (d_ack !== 1'b1) begin n_errors++; $display("FAIL cont_c2_d_ack: got %h want 1", d_ack); end
    n_checks++; if (d_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL cont_c2_d_rdata: got %h want deadbeef", d_rdata); end
    n_checks++; if (pipe_load !== 1'b0) begin n_errors++; $display("FAIL cont_c2_pipe_load: got %h want 0", pipe_load); end
    n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL cont_c2_bubble: got %h want 0", mem_en); end
    mem_rdata = 32'h00A00113;
    tick(); #1;
    n_checks++; if (mem_en !== 1'b1) begin n_errors++; $display("FAIL cont_c3_mem_en: got %h want 1", mem_en); end
    n_checks++; if (mem_addr !== 32'h104) begin n_errors++; $display("FAIL cont_c3_addr: got %h want 00000104", mem_addr); end
    n_checks++; if (pipe_load !== 1'b0) begin n_errors++; $display("FAIL cont_c3_pipe_load: got %h want 0", pipe_load); end
    tick(); #1;
    n_checks++; if (if_ack !== 1'b1) begin n_errors++; $display("FAIL cont_c4_if_ack: got %h want 1", if_ack); end
    n_checks++; if (if_rdata !== 32'h00A00113) begin n_errors++; $display("FAIL cont_c4_if_rdata: got %h want 00a00113", if_rdata); end
    n_checks++; if (pipe_load !== 1'b1) begin n_errors++; $display("FAIL cont_c4_pipe_load: got %h want 1", pipe_load); end
    tick(); #1;
    // Requests still high after pipe_load: done flags must have cleared.
    n_checks++; if (pipe_load !== 1'b0) begin n_errors++; $display("FAIL cont_c5_flags_clear: got %h want 0", pipe_load); end
    n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL cont_c5_mem_en: got %h want 0", mem_en); end
    if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; mem_rdata = 32'hAA; mem_ready = 1'b1;
    tick(); tick(); #1;
    n_checks++; if (d_rdata !== 32'hAA) begin n_errors++; $display("FAIL store_prior_load: got %h want 000000aa", d_rdata); end
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_wdata = 32'h1234; d_addr = 32'h44;
    mem_rdata = 32'h55555555;
    tick(); #1;
    n_checks++; if (mem_we !== 1'b1) begin n_errors++; $display("FAIL store_we: got %h want 1", mem_we); end
    n_checks++; if (mem_be !== 4'h3) begin n_errors++; $display("FAIL store_be: got %h want 3", mem_be); end
    n_checks++; if (mem_wdata !== 32'h1234) begin n_errors++; $display("FAIL store_wdata: got %h want 00001234", mem_wdata); end
    n_checks++; if (mem_addr !== 32'h44) begin n_errors++; $display("FAIL store_addr: got %h want 00000044", mem_addr); end
    tick(); #1;
    n_checks++; if (d_ack !== 1'b1) begin n_errors++; $display("FAIL store_ack: got %h want 1", d_ack); end
    n_checks++; if (d_rdata !== 32'hAA) begin n_errors++; $display("FAIL store_rdata_kept: got %h want 000000aa", d_rdata); end
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    tick();
  endtask

  task automatic test_timeout_edge();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_ready = 1'b0;
    tick(); tick(); tick(); tick();
    mem_ready = 1'b1; mem_rdata = 32'h77; #1;
    n_checks++; if (mem_en_t !== 1'b1) begin n_errors++; $display("FAIL tedge_mem_en: got %h want 1", mem_en_t); end
    tick(); #1;
    n_checks++; if (d_ack_t !== 1'b1) begin n_errors++; $display("FAIL tedge_ack: got %h want 1", d_ack_t); end
    n_checks++; if (d_rdata_t !== 32'h77) begin n_errors++; $display("FAIL tedge_rdata: got %h want 00000077", d_rdata_t); end
    n_checks++; if (err_t !== 1'b0) begin n_errors++; $display("FAIL tedge_err: got %h want 0", err_t); end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304; mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(); #1;
      n_checks++; if (mem_en_t !== 1'b1) begin n_errors++; $display("FAIL tout_c%0d_mem_en: got %h want 1", i, mem_en_t); end
      n_checks++; if (d_ack_t !== 1'b0) begin n_errors++; $display("FAIL tout_c%0d_ack: got %h want 0", i, d_ack_t); end
    end
    tick(); #1;
    n_checks++; if (d_ack_t !== 1'b1) begin n_errors++; $display("FAIL tout_ack: got %h want 1", d_ack_t); end
    n_checks++; if (err_t !== 1'b1) begin n_errors++; $display("FAIL tout_err: got %h want 1", err_t); end
    n_checks++; if (d_rdata_t !== 32'h0) begin n_errors++; $display("FAIL tout_rdata: got %h want 0", d_rdata_t); end
    n_checks++; if (mem_en_t !== 1'b0) begin n_errors++; $display("FAIL tout_mem_en: got %h want 0", mem_en_t); end
    n_checks++; if (pipe_load_t !== 1'b1) begin n_errors++; $display("FAIL tout_pipe_load: got %h want 1", pipe_load_t); end
    d_req = 1'b0; mem_ready = 1'b1;
    tick(); tick(); #1;
    n_checks++; if (err_t !== 1'b1) begin n_errors++; $display("FAIL tout_sticky: got %h want 1", err_t); end
    rst = 1'b0;
    tick(); #1;
    n_checks++; if (err_t !== 1'b0) begin n_errors++; $display("FAIL tout_reset_clear: got %h want 0", err_t); end
    rst = 1'b1; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    if_req = 1'b1; if_addr = 32'h200; mem_ready = 1'b0; mem_rdata = 32'hCAFEF00D;
    for (int i = 1; i <= 5; i++) begin
      tick(); #1;
      n_checks++; if (mem_en !== 1'b1) begin n_errors++; $display("FAIL wait_c%0d_mem_en: got %h want 1", i, mem_en); end
      n_checks++; if (mem_addr !== 32'h200) begin n_errors++; $display("FAIL wait_c%0d_addr: got %h want 00000200", i, mem_addr); end
      n_checks++; if (mem_be !== 4'hF) begin n_errors++; $display("FAIL wait_c%0d_be: got %h want f", i, mem_be); end
      n_checks++; if (if_ack !== 1'b0) begin n_errors++; $display("FAIL wait_c%0d_ack: got %h want 0", i, if_ack); end
      n_checks++; if (pipe_load !== 1'b0) begin n_errors++; $display("FAIL wait_c%0d_pipe_load: got %h want 0", i, pipe_load); end
      if_addr = 32'hFFF;
    end
    tick(); #1;
    n_checks++; if (mem_addr !== 32'h200) begin n_errors++; $display("FAIL wait_c6_addr: got %h want 00000200", mem_addr); end
    mem_ready = 1'b1;
    tick(); #1;
    n_checks++; if (if_ack !== 1'b1) begin n_errors++; $display("FAIL wait_ack: got %h want 1", if_ack); end
    n_checks++; if (if_rdata !== 32'hCAFEF00D) begin n_errors++; $display("FAIL wait_rdata: got %h want cafef00d", if_rdata); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL wait_err: got %h want 0", err); end
    n_checks++; if (pipe_load !== 1'b1) begin n_errors++; $display("FAIL wait_pipe_load: got %h want 1", pipe_load); end
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_be = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_timeout_edge();
    test_timeout();
    test_wait_states();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
